// File: rtl/display_mux.sv
// Four-digit multiplexed 7-segment display driver.
// Scans sec_ones, sec_tens, min_ones, min_tens in turn, one slot per
// DIGIT_CYCLES clocks. The first cycle of every slot is dead time, so
// ghosting between digits is avoided. Segment inputs are captured once per
// frame, which keeps a frame from showing a mix of old and new digits.
// Optional leading-zero blanking, a colon on digit 2, and whole-display
// blinking with a period of 2*BLINK_HALF frames.
module display_mux #(
  parameter int DIGIT_CYCLES   = 25000,
  parameter int BLINK_HALF     = 64,
  parameter bit ACTIVE_LOW_OUT = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] sec_ones_segs,
  input  logic [6:0] sec_tens_segs,
  input  logic [6:0] min_ones_segs,
  input  logic [6:0] min_tens_segs,
  input  logic       blank_lead,
  input  logic       blink,
  input  logic       colon_en,
  output logic [6:0] seg_out,
  output logic [3:0] an,
  output logic       dp_out,
  output logic       frame_tick
);

  localparam int CNT_W = $clog2(DIGIT_CYCLES);
  localparam int FC_W  = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIGIT_CYCLES - 1);
  localparam logic [FC_W-1:0]  FC_LAST  = FC_W'(BLINK_HALF - 1);

  // XOR masks that turn active-high internal values into panel polarity;
  // they also double as the "everything off" drive levels.
  localparam logic [6:0] SEG_INV = ACTIVE_LOW_OUT ? 7'h7F : 7'h00;
  localparam logic [3:0] AN_INV  = ACTIVE_LOW_OUT ? 4'hF : 4'h0;
  localparam logic       DP_INV  = ACTIVE_LOW_OUT;

  localparam logic [6:0] SEG_ZERO = 7'h3F;

  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [1:0]       idx_reg, idx_next;
  logic [FC_W-1:0]  frame_cnt_reg, frame_cnt_next;
  logic             phase_reg, phase_next;
  logic [6:0]       snap_reg [4];
  logic [6:0]       seg_in   [4];

  logic             cnt_wrap;
  logic             frame_end;
  logic             snap_load;
  logic             cnt_live;
  logic             blink_off;
  logic [3:0]       blank_vec;
  logic [3:0]       en_vec;
  logic             dp_on;
  logic [6:0]       seg_sel;

  assign seg_in[0] = sec_ones_segs;
  assign seg_in[1] = sec_tens_segs;
  assign seg_in[2] = min_ones_segs;
  assign seg_in[3] = min_tens_segs;

  assign cnt_wrap  = (cnt_reg == CNT_LAST);
  assign frame_end = cnt_wrap && (idx_reg == 2'd3);
  assign snap_load = (cnt_reg == '0) && (idx_reg == 2'd0);
  assign cnt_live  = (cnt_reg != '0);
  assign blink_off = blink && phase_reg;

  // Next-state for the scan position and the blink frame counter.
  always_comb begin
    cnt_next       = cnt_reg + 1'b1;
    idx_next       = idx_reg;
    frame_cnt_next = frame_cnt_reg;
    phase_next     = phase_reg;
    if (cnt_wrap) begin
      cnt_next = '0;
      idx_next = idx_reg + 2'd1;
    end
    if (!blink) begin
      // Holding at zero guarantees a new blink request starts visible.
      frame_cnt_next = '0;
      phase_next     = 1'b0;
    end else if (frame_end) begin
      if (frame_cnt_reg == FC_LAST) begin
        frame_cnt_next = '0;
        phase_next     = ~phase_reg;
      end else begin
        frame_cnt_next = frame_cnt_reg + 1'b1;
      end
    end
  end

  // Scan position and blink state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_reg       <= '0;
      idx_reg       <= 2'd0;
      frame_cnt_reg <= '0;
      phase_reg     <= 1'b0;
    end else begin
      cnt_reg       <= cnt_next;
      idx_reg       <= idx_next;
      frame_cnt_reg <= frame_cnt_next;
      phase_reg     <= phase_next;
    end
  end

  // Capture all four digits together at the start of each frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) snap_reg[i] <= '0;
    end else if (snap_load) begin
      for (int i = 0; i < 4; i++) snap_reg[i] <= seg_in[i];
    end
  end

  // Blanking chains: min_ones only blanks when min_tens is blanked too.
  assign blank_vec[3] = blank_lead && (snap_reg[3] == SEG_ZERO);
  assign blank_vec[2] = blank_vec[3] && (snap_reg[2] == SEG_ZERO);
  assign blank_vec[1] = 1'b0;
  assign blank_vec[0] = 1'b0;

  // Per-digit enable: selected slot, past dead time, not blanked or blinked.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_en
      assign en_vec[gi] = cnt_live && (idx_reg == 2'(gi)) &&
                          !blank_vec[gi] && !blink_off;
    end
  endgenerate

  assign dp_on   = en_vec[2] && colon_en;
  assign seg_sel = snap_reg[idx_reg];

  // Registered panel drive; reset parks everything in the off state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seg_out    <= SEG_INV;
      an         <= AN_INV;
      dp_out     <= DP_INV;
      frame_tick <= 1'b0;
    end else begin
      seg_out    <= seg_sel ^ SEG_INV;
      an         <= en_vec ^ AN_INV;
      dp_out     <= dp_on ^ DP_INV;
      frame_tick <= frame_end;
    end
  end

endmodule

// File: tb/tb_display_mux.sv
// Directed bench for display_mux with DIGIT_CYCLES=4, BLINK_HALF=2,
// active-low panel. Outputs are sampled on the falling clock edge.
// "p" below is the index of the rising edge since reset release (0-based),
// so the outputs seen after edge p reflect slot (p/4)%4, cnt p%4.
module tb_display_mux;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [6:0] sec_ones_segs = 7'h00;
  logic [6:0] sec_tens_segs = 7'h00;
  logic [6:0] min_ones_segs = 7'h00;
  logic [6:0] min_tens_segs = 7'h00;
  logic       blank_lead = 1'b0;
  logic       blink = 1'b0;
  logic       colon_en = 1'b0;
  logic [6:0] seg_out;
  logic [3:0] an;
  logic       dp_out;
  logic       frame_tick;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int cyc      = 0;

  // Expected active-low drive for inputs 06/5B/4F/66, per slot.
  logic [3:0] an_tab  [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
  logic [6:0] seg_tab [4] = '{7'h79, 7'h24, 7'h30, 7'h19};

  display_mux #(
    .DIGIT_CYCLES  (4),
    .BLINK_HALF    (2),
    .ACTIVE_LOW_OUT(1'b1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .sec_ones_segs(sec_ones_segs),
    .sec_tens_segs(sec_tens_segs),
    .min_ones_segs(min_ones_segs),
    .min_tens_segs(min_tens_segs),
    .blank_lead   (blank_lead),
    .blink        (blink),
    .colon_en     (colon_en),
    .seg_out      (seg_out),
    .an           (an),
    .dp_out       (dp_out),
    .frame_tick   (frame_tick)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic set_digits();
    sec_ones_segs = 7'h06;
    sec_tens_segs = 7'h5B;
    min_ones_segs = 7'h4F;
    min_tens_segs = 7'h66;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    cyc = 0;
  endtask

  task automatic test_reset();
    sec_ones_segs = 7'h12; sec_tens_segs = 7'h34;
    min_ones_segs = 7'h56; min_tens_segs = 7'h78;
    blank_lead = 1'b1; blink = 1'b1; colon_en = 1'b1;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk_cnt++; if (an !== 4'hF) $display("FAIL reset_an: got %h expected F", an); else pass_cnt++;
    chk_cnt++; if (seg_out !== 7'h7F) $display("FAIL reset_seg: got %h expected 7F", seg_out); else pass_cnt++;
    chk_cnt++; if (dp_out !== 1'b1) $display("FAIL reset_dp: got %b expected 1", dp_out); else pass_cnt++;
    chk_cnt++; if (frame_tick !== 1'b0) $display("FAIL reset_tick: got %b expected 0", frame_tick); else pass_cnt++;
    blank_lead = 1'b0; blink = 1'b0; colon_en = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_scan();
    int slot, c;
    logic [3:0] e_an; logic [6:0] e_seg; logic e_dp, e_tick;
    set_digits(); blank_lead = 1'b0; blink = 1'b0; colon_en = 1'b1;
    do_reset();
    for (int p = 0; p < 40; p++) begin
      step();
      slot = (p / 4) % 4; c = p % 4;
      e_an   = (c == 0) ? 4'hF : an_tab[slot];
      // Very first dead cycle still shows the reset-cleared snapshot.
      e_seg  = (p == 0) ? 7'h7F : seg_tab[slot];
      e_dp   = !(c != 0 && slot == 2);
      e_tick = (p % 16 == 15);
      chk_cnt++; if (an !== e_an) $display("FAIL scan_an p=%0d: got %h expected %h", p, an, e_an); else pass_cnt++;
      chk_cnt++; if (seg_out !== e_seg) $display("FAIL scan_seg p=%0d: got %h expected %h", p, seg_out, e_seg); else pass_cnt++;
      chk_cnt++; if (dp_out !== e_dp) $display("FAIL scan_dp p=%0d: got %b expected %b", p, dp_out, e_dp); else pass_cnt++;
      chk_cnt++; if (frame_tick !== e_tick) $display("FAIL scan_tick p=%0d: got %b expected %b", p, frame_tick, e_tick); else pass_cnt++;
    end
    $display("test_scan done");
  endtask

  task automatic test_blanking();
    int slot, c, f;
    logic [3:0] e_an; logic e_dp;
    sec_ones_segs = 7'h06; sec_tens_segs = 7'h5B;
    min_ones_segs = 7'h3F; min_tens_segs = 7'h3F;
    blank_lead = 1'b1; blink = 1'b0; colon_en = 1'b1;
    do_reset();
    for (int p = 0; p < 32; p++) begin
      if (p == 16) min_ones_segs = 7'h06;
      step();
      slot = (p / 4) % 4; c = p % 4; f = p / 16;
      if (c == 0 || slot == 3 || (slot == 2 && f == 0)) e_an = 4'hF;
      else e_an = an_tab[slot];
      e_dp = !(c != 0 && slot == 2 && f == 1);
      chk_cnt++; if (an !== e_an) $display("FAIL blank_an p=%0d: got %h expected %h", p, an, e_an); else pass_cnt++;
      chk_cnt++; if (dp_out !== e_dp) $display("FAIL blank_dp p=%0d: got %b expected %b", p, dp_out, e_dp); else pass_cnt++;
    end
    blank_lead = 1'b0;
    $display("test_blanking done");
  endtask

  task automatic test_snapshot();
    int slot;
    logic [6:0] e_seg;
    set_digits(); blank_lead = 1'b0; blink = 1'b0; colon_en = 1'b1;
    do_reset();
    for (int p = 0; p < 24; p++) begin
      if (p == 9) sec_ones_segs = 7'h4F;
      step();
      slot = (p / 4) % 4;
      if (p == 0) e_seg = 7'h7F;
      else if (p >= 17 && slot == 0) e_seg = 7'h30;
      else e_seg = seg_tab[slot];
      chk_cnt++; if (seg_out !== e_seg) $display("FAIL snap_seg p=%0d: got %h expected %h", p, seg_out, e_seg); else pass_cnt++;
    end
    $display("test_snapshot done");
  endtask

  task automatic test_blink();
    int slot, c;
    logic off;
    logic [3:0] e_an; logic e_dp;
    set_digits(); blank_lead = 1'b0; colon_en = 1'b1; blink = 1'b1;
    do_reset();
    for (int p = 0; p < 112; p++) begin
      if (p == 102) blink = 1'b0;
      step();
      slot = (p / 4) % 4; c = p % 4;
      off  = (p < 102) && ((p / 32) % 2 == 1);
      e_an = (off || c == 0) ? 4'hF : an_tab[slot];
      e_dp = !(!off && c != 0 && slot == 2);
      chk_cnt++; if (an !== e_an) $display("FAIL blink_an p=%0d: got %h expected %h", p, an, e_an); else pass_cnt++;
      chk_cnt++; if (dp_out !== e_dp) $display("FAIL blink_dp p=%0d: got %b expected %b", p, dp_out, e_dp); else pass_cnt++;
    end
    $display("test_blink done");
  endtask

  task automatic test_mid_reset();
    int slot, c;
    logic [3:0] e_an; logic e_tick;
    set_digits(); blank_lead = 1'b0; blink = 1'b0; colon_en = 1'b1;
    do_reset();
    for (int p = 0; p < 10; p++) step();
    chk_cnt++; if (an !== 4'hB) $display("FAIL mid_pre_an: got %h expected B", an); else pass_cnt++;
    #2 rst = 1'b0;
    #1;
    chk_cnt++; if (an !== 4'hF) $display("FAIL mid_async_an: got %h expected F", an); else pass_cnt++;
    chk_cnt++; if (seg_out !== 7'h7F) $display("FAIL mid_async_seg: got %h expected 7F", seg_out); else pass_cnt++;
    chk_cnt++; if (dp_out !== 1'b1) $display("FAIL mid_async_dp: got %b expected 1", dp_out); else pass_cnt++;
    @(negedge clk);
    rst = 1'b1;
    cyc = 0;
    for (int p = 0; p < 20; p++) begin
      step();
      slot = (p / 4) % 4; c = p % 4;
      e_an   = (c == 0) ? 4'hF : an_tab[slot];
      e_tick = (p == 15);
      chk_cnt++; if (an !== e_an) $display("FAIL mid_an p=%0d: got %h expected %h", p, an, e_an); else pass_cnt++;
      chk_cnt++; if (frame_tick !== e_tick) $display("FAIL mid_tick p=%0d: got %b expected %b", p, frame_tick, e_tick); else pass_cnt++;
    end
    $display("test_mid_reset done");
  endtask

  initial begin
    test_reset();
    test_scan();
    test_blanking();
    test_snapshot();
    test_blink();
    test_mid_reset();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
